// File: rtl/demux_pkg.sv
// Shared types and constants for the serial-to-parallel lane demux sequencer.
package demux_pkg;

  localparam int NB_LANE = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } stateT;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_IQ   = 1'b1;

  localparam logic [SEL_W-1:0] LAST_SEL_BYTE = 3'd7;
  localparam logic [SEL_W-1:0] LAST_SEL_IQ   = 3'd1;

  // Final lane index for the latched mode; the word completes when this lane is written.
  function automatic logic [SEL_W-1:0] lastSel(input logic mode);
    return (mode == MODE_IQ) ? LAST_SEL_IQ : LAST_SEL_BYTE;
  endfunction

endpackage

// File: rtl/demux_lane_sched_demux181.sv
// 1:8 demultiplexer: routes inData onto the one-hot output selected by inSel.
module DEMUX181 (
  input  logic       inData,
  input  logic [2:0] inSel,
  output logic [7:0] outData
);

  always_comb begin
    outData        = '0;
    outData[inSel] = inData;
  end

endmodule

// File: rtl/demux_lane_sched.sv
// Lane select sequencer: assembles serial bits into 8-lane (byte) or 2-lane (I/Q) words
// and hands each finished word downstream over a valid/ready handshake.
module demux_lane_sched #(
  parameter int NB_LANE = 8,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               inStart,
  input  logic               inMode,
  input  logic               inData,
  input  logic               inValid,
  output logic               outReady,
  output logic [SEL_W-1:0]   outSel,
  output logic [NB_LANE-1:0] outData,
  output logic               outValid,
  input  logic               inReady,
  output logic               outBusy
);

  import demux_pkg::*;

  stateT               state, stateNext;
  logic                mode, modeNext;
  logic [SEL_W-1:0]    sel, selNext;
  logic [NB_LANE-1:0]  lanes, lanesNext;
  logic [NB_LANE-1:0]  laneWe;
  logic                valid, validNext;
  logic                accept;

  assign accept = inValid && outReady;

  // The same select that steers the external demux also produces our lane write enables.
  DEMUX181 uDemux (
    .inData (accept),
    .inSel  (sel),
    .outData(laneWe)
  );

  always_comb begin
    stateNext = state;
    modeNext  = mode;
    selNext   = sel;
    lanesNext = lanes;
    validNext = valid;

    // A restart overrides any accept or downstream transfer in the same cycle.
    if (inStart) begin
      stateNext = FILL;
      modeNext  = inMode;
      selNext   = '0;
      lanesNext = '0;
      validNext = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        FILL: begin
          if (accept) begin
            for (int i = 0; i < NB_LANE; i++) begin
              if (laneWe[i]) lanesNext[i] = inData;
            end
            if (sel == lastSel(mode)) begin
              stateNext = HOLD;
              validNext = 1'b1;
            end else begin
              selNext = sel + 1'b1;
            end
          end
        end
        HOLD: begin
          if (inReady) begin
            stateNext = FILL;
            selNext   = '0;
            lanesNext = '0;
            validNext = 1'b0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Ready and busy are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      mode     <= MODE_BYTE;
      sel      <= '0;
      lanes    <= '0;
      valid    <= 1'b0;
      outReady <= 1'b0;
      outBusy  <= 1'b0;
    end else begin
      state    <= stateNext;
      mode     <= modeNext;
      sel      <= selNext;
      lanes    <= lanesNext;
      valid    <= validNext;
      outReady <= (stateNext == FILL);
      outBusy  <= (stateNext != IDLE);
    end
  end

  assign outSel   = sel;
  assign outData  = lanes;
  assign outValid = valid;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Directed bench for demux_lane_sched with a word scoreboard checked on every downstream transfer.
module tb_demux_lane_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic       inStart, inMode, inData, inValid, inReady;
  logic       outReady, outValid, outBusy;
  logic [2:0] outSel;
  logic [7:0] outData;

  int passCount  = 0;
  int checkCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] byteBits;

  demux_lane_sched #(.NB_LANE(8), .SEL_W(3)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .inStart (inStart),
    .inMode  (inMode),
    .inData  (inData),
    .inValid (inValid),
    .outReady(outReady),
    .outSel  (outSel),
    .outData (outData),
    .outValid(outValid),
    .inReady (inReady),
    .outBusy (outBusy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs; returns #1 after the edge that sampled them.
  task automatic applyStimulus(input logic start, input logic mode, input logic data,
                               input logic valid, input logic ready);
    inStart = start;
    inMode  = mode;
    inData  = data;
    inValid = valid;
    inReady = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "Ready"}, 32'(outReady), 32'd0);
    checkOutput({tag, "Sel"},   32'(outSel),   32'd0);
    checkOutput({tag, "Data"},  32'(outData),  32'd0);
    checkOutput({tag, "Valid"}, 32'(outValid), 32'd0);
    checkOutput({tag, "Busy"},  32'(outBusy),  32'd0);
  endtask

  // Every downstream transfer must match the oldest expected word; an empty queue yields an impossible value.
  always @(negedge clk) begin
    if (resetn && outValid && inReady) begin
      logic [8:0] expWord;
      expWord = (expQ.size() > 0) ? {1'b0, expQ.pop_front()} : 9'h1FF;
      checkOutput("wordOut", 32'({1'b0, outData}), 32'(expWord));
    end
  end

  initial begin
    resetn = 1'b0;
    inStart = 0; inMode = 0; inData = 0; inValid = 0; inReady = 0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    resetn = 1'b1;

    // inValid while IDLE is ignored
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("idleReady", 32'(outReady), 32'd0);
    checkOutput("idleBusy",  32'(outBusy),  32'd0);
    checkOutput("idleValid", 32'(outValid), 32'd0);

    // Byte mode, downstream always ready
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("startReady", 32'(outReady), 32'd1);
    checkOutput("startBusy",  32'(outBusy),  32'd1);
    byteBits = 8'h4D;
    expQ.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("byteSel%0d", i), 32'(outSel), 32'(i));
      applyStimulus(0, 0, byteBits[i], 1, 1);
    end
    checkOutput("byteValid", 32'(outValid), 32'd1);
    checkOutput("byteData",  32'(outData),  32'h4D);
    checkOutput("holdReady", 32'(outReady), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("validOneCycle", 32'(outValid), 32'd0);
    checkOutput("nextSel",       32'(outSel),   32'd0);
    checkOutput("refillReady",   32'(outReady), 32'd1);

    // Backpressure: word must stay frozen while downstream stalls
    expQ.push_back(8'h4D);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, byteBits[i], 1, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bpValid%0d", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("bpData%0d", i),  32'(outData),  32'h4D);
      checkOutput($sformatf("bpReady%0d", i), 32'(outReady), 32'd0);
      applyStimulus(0, 0, 1, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("bpResumeReady", 32'(outReady), 32'd1);
    checkOutput("bpResumeValid", 32'(outValid), 32'd0);

    // I/Q mode with gaps between bits
    applyStimulus(1, 1, 0, 0, 1);
    expQ.push_back(8'h01);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("iqSelA", 32'(outSel), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("iqGapSel", 32'(outSel), 32'd1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("iqValid1", 32'(outValid), 32'd1);
    checkOutput("iqData1",  32'(outData),  32'h01);
    checkOutput("iqHoldSel", 32'(outSel), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("iqSelWrap", 32'(outSel), 32'd0);
    expQ.push_back(8'h02);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("iqData2", 32'(outData), 32'h02);
    applyStimulus(0, 0, 0, 0, 1);

    // Abort A: restart mid-byte coinciding with an accept, no residue
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("abortAData", 32'(outData), 32'd0);
    checkOutput("abortASel",  32'(outSel),  32'd0);
    expQ.push_back(8'h03);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("abortAWord", 32'(outData), 32'h03);
    applyStimulus(0, 0, 0, 0, 1);

    // Abort B: restart during HOLD discards the pending word
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("abortBHold", 32'(outValid), 32'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("abortBValid", 32'(outValid), 32'd0);
    checkOutput("abortBData",  32'(outData),  32'd0);
    checkOutput("abortBReady", 32'(outReady), 32'd1);

    // Asynchronous reset between edges while holding a word
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("preResetValid", 32'(outValid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkIdleOutputs("asyncReset");
    #3 resetn = 1'b1;
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("postResetBusy",  32'(outBusy),  32'd0);
    checkOutput("postResetReady", 32'(outReady), 32'd0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("restartBusy", 32'(outBusy), 32'd1);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/demux_lane_sched.md
# demux_lane_sched

Sequencer for the serial-to-parallel lane demux path of the Zigbee baseband. Accepts a serial bit/chip stream through a valid/ready handshake, steps a lane select across 8 lanes (1:8 byte mode) or 2 lanes (1:2 I/Q mode), and presents each completed word downstream with valid/ready. It drives the same select an external DEMUX181 uses, so lane routing stays cycle-aligned with the assembled word.

## Interface
Parameters:
- NB_LANE, 8, lane count in byte mode; fixed at 8 for this revision.
- SEL_W, 3, select width, equal to log2(NB_LANE).

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inStart  in  1  frame start pulse; restarts assembly and latches inMode.
- inMode  in  1  0 = 1:8 byte mode, 1 = 1:2 I/Q mode; sampled only when inStart is high.
- inData  in  1  serial bit/chip from upstream.
- inValid  in  1  upstream has a bit this cycle.
- outReady  out  1  block accepts inData this cycle.
- outSel  out  SEL_W  lane that the next accepted bit is written to.
- outData  out  NB_LANE  assembled word, bit 0 = first bit received.
- outValid  out  1  outData holds a complete word.
- inReady  in  1  downstream accepts the word this cycle.
- outBusy  out  1  high whenever the FSM is not IDLE.

## Operation
- Reset values: outReady=0, outSel=0, outData=0, outValid=0, outBusy=0. The FSM enters IDLE and the mode register resets to 0.
- FSM states and transitions:
  - IDLE: outReady=0. On inStart it goes to FILL, sets sel=0, clears the lanes, and latches mode.
  - FILL: outReady=1. An accept is inValid && outReady. Each accept writes lane[sel]=inData and sets sel=sel+1.
  - Last lane is 7 in mode 0 and 1 in mode 1. An accept at the last lane moves to HOLD with outValid=1.
  - HOLD: outReady=0. outData and outValid stay stable. When inReady is high, the FSM goes to FILL next cycle with sel=0, lanes cleared and outValid=0.
- inValid low in FILL: sel and the lanes hold, with no bubble penalty.
- Mode 1 word: outData = {6'b0, Q, I}, where I is the first bit. Bits [7:2] are always 0.
- inStart in any state has priority over every other event. It goes to FILL, sets sel=0, clears the lanes, drops outValid (discarding any pending word) and relatches mode.
- inStart coinciding with an accept: the bit is discarded and the restart wins.
- inStart coinciding with inReady in HOLD: the restart wins and the word counts as not delivered.
- Wrap-around: sel never exceeds the last lane. It returns to 0 only through HOLD exit or inStart.
- No stop input: the FSM leaves FILL/HOLD only through reset. IDLE is reached only from reset.

## Timing
- All outputs are registered. There is no combinational path from inValid/inReady to any output.
- outSel changes on the clock edge after each accept. It is valid in the same cycle as outReady for the next bit.
- Latency: outValid rises on the edge that captures the final bit, i.e. it is visible the cycle after the last accept.
- Throughput: mode 0 needs 8 accept cycles + 1 HOLD cycle (minimum) + 0 refill penalty, so 9 cycles per byte with inReady held high. Mode 1 needs 3 cycles per pair.
- Handshake:
  - A word transfers on the cycle outValid && inReady.
  - outValid/outData must not change until that transfer, except on inStart or reset.
- resetn is asynchronous. Assertion clears all state immediately, including mid-FILL or mid-HOLD. Deassertion is synchronized externally.

## Structure
- Package demux_pkg:
  - state enum {IDLE, FILL, HOLD}.
  - NB_LANE, SEL_W.
  - MODE_BYTE=1'b0, MODE_IQ=1'b1.
  - LAST_SEL_BYTE=3'd7, LAST_SEL_IQ=3'd1.
- One sub-module: an instance of the existing DEMUX181, with inData = accept strobe and inSel = sel. Its one-hot outData provides the per-lane write enables. The lane registers, FSM and select counter live in demux_lane_sched.

## Test plan
- Reset, no stimulus: all outputs 0 and outBusy=0. Pulsing inValid while IDLE leaves outReady=0 and no word is produced.
- Mode 0, inStart, then bits 1,0,1,1,0,0,1,0 on consecutive cycles with inReady=1:
  - outSel steps 0..7.
  - outData=8'h4D with outValid high for exactly 1 cycle.
  - The next frame starts at sel=0.
- Backpressure: same byte with inReady=0 for 5 cycles. outValid=1 and outData=8'h4D stay stable, and outReady=0. Raising inReady completes the transfer, and FILL resumes the next cycle.
- Mode 1, bits 1,0 then 0,1 (inValid with 1-cycle gaps): words 8'h01 then 8'h02 are delivered. sel only alternates 0/1 and holds during the gaps.
- Abort:
  - Case A: 3 bits accepted, then inStart with inMode=1, then bits 1,1. The word is 8'h03, with no residue from the first bits.
  - Case B: inStart during HOLD with inReady=0 drops outValid.
- Asynchronous reset asserted mid-HOLD, between clock edges: outputs drop to 0 without waiting for an edge. After release, the FSM is IDLE until inStart.
